// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: default timing, mode
// encoding and the colour-bar palette.
package vga_pkg;

   localparam int DEF_H_DISPLAY   = 640;
   localparam int DEF_H_FRONT     = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BACK      = 48;
   localparam int DEF_V_DISPLAY   = 480;
   localparam int DEF_V_FRONT     = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BACK      = 33;
   localparam int DEF_COLOR_W     = 4;
   localparam int DEF_SQUARE_SIZE = 60;
   localparam int DEF_BOARD_SIZE  = 480;
   localparam int DEF_SCROLL_STEP = 1;

   typedef enum logic [1:0] {
      MODE_CHESS  = 2'd0,
      MODE_BARS   = 2'd1,
      MODE_SOLID  = 2'd2,
      MODE_SCROLL = 2'd3
   } mode_t;

   // 3-bit {R,G,B}, bar 0 leftmost; each bit is replicated across a channel
   localparam logic [0:7][2:0] BAR_RGB = {
      3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
   };

endpackage

// File: rtl/vga_timing.sv
// Raster counters with raw sync, active-area flag and line/frame strobes,
// all decoded combinationally from the current counter state.
module vga_timing import vga_pkg::*; #(
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter int HW = $clog2(H_DISPLAY + H_FRONT + H_SYNC + H_BACK),
   parameter int VW = $clog2(V_DISPLAY + V_FRONT + V_SYNC + V_BACK)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [HW-1:0] o_h,
   output logic [VW-1:0] o_v,
   output logic          o_hs_act,
   output logic          o_vs_act,
   output logic          o_active,
   output logic          o_line_end,
   output logic          o_frame_start
);

   localparam logic [HW-1:0] H_LAST   = HW'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [HW-1:0] HS_FIRST = HW'(H_DISPLAY + H_FRONT);
   localparam logic [HW-1:0] HS_LAST  = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [VW-1:0] VS_FIRST = VW'(V_DISPLAY + V_FRONT);
   localparam logic [VW-1:0] VS_LAST  = VW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_DISPLAY);
   localparam logic [VW-1:0] V_ACT    = VW'(V_DISPLAY);

   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (r_h == H_LAST) begin
         r_h <= '0;
         r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
         r_h <= r_h + 1'b1;
      end
   end

   assign o_h           = r_h;
   assign o_v           = r_v;
   assign o_hs_act      = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
   assign o_vs_act      = (r_v >= VS_FIRST) && (r_v <= VS_LAST);
   assign o_active      = (r_h < H_ACT) && (r_v < V_ACT);
   assign o_line_end    = (r_h == H_LAST);
   assign o_frame_start = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: chessboard, colour bars, solid red and a
// horizontally scrolling chessboard, with registered sync/de/rgb outputs.
module vga_pattern_gen import vga_pkg::*; #(
   parameter int   H_DISPLAY   = DEF_H_DISPLAY,
   parameter int   H_FRONT     = DEF_H_FRONT,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   H_BACK      = DEF_H_BACK,
   parameter int   V_DISPLAY   = DEF_V_DISPLAY,
   parameter int   V_FRONT     = DEF_V_FRONT,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter int   V_BACK      = DEF_V_BACK,
   parameter logic SYNC_POL    = 1'b0,
   parameter int   COLOR_W     = DEF_COLOR_W,
   parameter int   SQUARE_SIZE = DEF_SQUARE_SIZE,
   parameter int   BOARD_SIZE  = DEF_BOARD_SIZE,
   parameter int   SCROLL_STEP = DEF_SCROLL_STEP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic               frame_start,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int X0      = (H_DISPLAY - BOARD_SIZE) / 2;
   localparam int Y0      = (V_DISPLAY - BOARD_SIZE) / 2;
   localparam int OW      = $clog2(2 * SQUARE_SIZE);
   localparam int BAR_W   = H_DISPLAY / 8;
   localparam int BW      = $clog2(BAR_W + 1);
   localparam int STEP_M  = SCROLL_STEP % (2 * SQUARE_SIZE);

   localparam logic [HW-1:0] X_LO     = HW'(X0);
   localparam logic [VW-1:0] Y_LO     = VW'(Y0);
   localparam logic [HW-1:0] BS_H     = HW'(BOARD_SIZE);
   localparam logic [VW-1:0] BS_V     = VW'(BOARD_SIZE);
   localparam logic [HW-1:0] X_RLD    = (X0 == 0) ? '0 : HW'(X0 - 1);
   localparam logic [VW-1:0] Y_RLD    = (Y0 == 0) ? VW'(V_TOTAL - 1) : VW'(Y0 - 1);
   localparam logic [OW-1:0] SQ_O     = OW'(SQUARE_SIZE);
   localparam logic [OW-1:0] SQ_LAST  = OW'(SQUARE_SIZE - 1);
   localparam logic [OW:0]   TWO_SQ   = (OW+1)'(2 * SQUARE_SIZE);
   localparam logic [OW:0]   STEP_O   = (OW+1)'(STEP_M);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   logic [HW-1:0] w_h;
   logic [VW-1:0] w_v;
   logic          w_hs_act, w_vs_act, w_active, w_line_end, w_fs;

   vga_timing #(
      .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
      .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
      .HW(HW), .VW(VW)
   ) u_timing (
      .clk(clk), .rst(rst), .o_h(w_h), .o_v(w_v),
      .o_hs_act(w_hs_act), .o_vs_act(w_vs_act), .o_active(w_active),
      .o_line_end(w_line_end), .o_frame_start(w_fs)
   );

   mode_t         r_mode_q;
   logic [OW-1:0] r_off, r_x_sub, r_y_sub;
   logic          r_x_par, r_y_par;
   logic [BW-1:0] r_bar_cnt;
   logic [2:0]    r_bar_idx;
   logic          r_hsync, r_vsync, r_de, r_fs;
   logic [2:0]    r_rgb3;

   // At (0,0) the new frame's mode and offset are not registered yet, so
   // use the values that are about to be loaded.
   mode_t         w_mode;
   logic [OW:0]   w_sum;
   logic [OW-1:0] w_off_adv, w_off, w_pre_sub, w_x_sub;
   logic          w_pre_par, w_x_par, w_in_board;
   logic [HW-1:0] w_xd;
   logic [VW-1:0] w_yd;
   logic [2:0]    w_rgb3;

   assign w_mode    = w_fs ? mode_t'(mode) : r_mode_q;
   assign w_sum     = {1'b0, r_off} + STEP_O;
   assign w_off_adv = (w_sum >= TWO_SQ) ? OW'(w_sum - TWO_SQ) : OW'(w_sum);
   assign w_off     = (w_fs && r_mode_q == MODE_SCROLL) ? w_off_adv : r_off;
   assign w_pre_par = (w_mode == MODE_SCROLL) && (w_off >= SQ_O);
   assign w_pre_sub = (w_mode != MODE_SCROLL) ? '0 : (w_pre_par ? w_off - SQ_O : w_off);
   assign w_x_sub   = (X0 == 0 && w_h == '0) ? w_pre_sub : r_x_sub;
   assign w_x_par   = (X0 == 0 && w_h == '0) ? w_pre_par : r_x_par;

   // Wrapping subtraction makes positions left/above the origin look huge.
   assign w_xd       = w_h - X_LO;
   assign w_yd       = w_v - Y_LO;
   assign w_in_board = (w_xd < BS_H) && (w_yd < BS_V);

   always_comb begin
      w_rgb3 = 3'b000;
      if (w_active) begin
         case (w_mode)
            MODE_BARS:  w_rgb3 = BAR_RGB[r_bar_idx];
            MODE_SOLID: w_rgb3 = 3'b100;
            default:    w_rgb3 = w_in_board ? {3{w_x_par ^ r_y_par}} : 3'b100;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode_q  <= MODE_CHESS;
         r_off     <= '0;
         r_x_sub   <= '0;
         r_x_par   <= 1'b0;
         r_y_sub   <= '0;
         r_y_par   <= 1'b0;
         r_bar_cnt <= '0;
         r_bar_idx <= '0;
         r_hsync   <= ~SYNC_POL;
         r_vsync   <= ~SYNC_POL;
         r_de      <= 1'b0;
         r_fs      <= 1'b0;
         r_rgb3    <= '0;
      end else begin
         if (w_fs) begin
            r_mode_q <= w_mode;
            r_off    <= w_off;
         end
         if (X0 != 0 && w_h == X_RLD) begin
            r_x_sub <= w_pre_sub;
            r_x_par <= w_pre_par;
         end else if (w_x_sub == SQ_LAST) begin
            r_x_sub <= '0;
            r_x_par <= ~w_x_par;
         end else begin
            r_x_sub <= w_x_sub + 1'b1;
            r_x_par <= w_x_par;
         end
         if (w_line_end) begin
            if (w_v == Y_RLD) begin
               r_y_sub <= '0;
               r_y_par <= 1'b0;
            end else if (r_y_sub == SQ_LAST) begin
               r_y_sub <= '0;
               r_y_par <= ~r_y_par;
            end else begin
               r_y_sub <= r_y_sub + 1'b1;
            end
         end
         if (w_line_end) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
         end else if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= r_bar_idx + 1'b1;
         end else begin
            r_bar_cnt <= r_bar_cnt + 1'b1;
         end
         r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
         r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
         r_de    <= w_active;
         r_fs    <= w_fs;
         r_rgb3  <= w_rgb3;
      end
   end

   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign frame_start = r_fs;
   assign r           = {COLOR_W{r_rgb3[2]}};
   assign g           = {COLOR_W{r_rgb3[1]}};
   assign b           = {COLOR_W{r_rgb3[0]}};

endmodule
